carregador_programa: RTL and testbench

Boot loader that sits directly upstream of the single-cycle processor and its instruction memory. It holds the processor in reset, receives a program as a byte stream over a valid/ready handshake, assembles big-endian 32-bit words, and writes them into the instruction memory write port. After an 8-bit checksum verifies, it releases the processor reset so fetch starts at PC 0.

---
 rtl/carregador_programa_pkg.sv | 27 ++
 rtl/carregador_programa_montador.sv | 34 +++
 rtl/carregador_programa.sv | 138 +++++++++++++
 tb/tb_carregador_programa.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/carregador_programa_pkg.sv
// Shared definitions for the program loader: FSM encoding, stream framing
// constants and state-class helpers used by the top and the word assembler.
package carregador_programa_pkg;

  localparam int BYTES_POR_PALAVRA = 4;
  localparam int BYTES_CABECALHO   = 2;

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    CONTAGEM = 3'd1,
    DADOS    = 3'd2,
    CHECKSUM = 3'd3,
    LIBERA   = 3'd4,
    EXECUTA  = 3'd5,
    ERRO     = 3'd6
  } estado_t;

  // States in which the upstream byte stream is consumed.
  function automatic logic aceita_bytes(input estado_t e);
    return (e == CONTAGEM) || (e == DADOS) || (e == CHECKSUM);
  endfunction

  function automatic logic em_carga(input estado_t e);
    return (e == CONTAGEM) || (e == DADOS) || (e == CHECKSUM) || (e == LIBERA);
  endfunction

endpackage

// File: rtl/carregador_programa_montador.sv
// Big-endian word assembler: keeps the first three bytes of a word and
// presents the full word combinationally while its fourth byte is accepted.
module montador_palavra
  import carregador_programa_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_limpar,
  input  logic        i_aceito,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_palavra,
  output logic        o_palavra_pronta
);

  logic [1:0]  r_idx;
  logic [23:0] r_parcial;

  assign o_palavra        = {r_parcial, i_byte};
  assign o_palavra_pronta = i_aceito && (r_idx == 2'(BYTES_POR_PALAVRA - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx     <= '0;
      r_parcial <= '0;
    end else if (i_limpar) begin
      r_idx     <= '0;
      r_parcial <= '0;
    end else if (i_aceito) begin
      r_idx     <= r_idx + 2'd1;
      r_parcial <= o_palavra[23:0];
    end
  end

endmodule

// File: rtl/carregador_programa.sv
// Boot loader: holds the processor in reset, writes a checksummed byte-stream
// program into instruction memory, then releases the processor reset.
module carregador_programa
  import carregador_programa_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int RELEASE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  carregar,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_dado,
  output logic                  byte_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  proc_reset,
  output logic                  ocupado,
  output logic                  erro,
  output logic [ADDR_WIDTH:0]   palavras,
  output estado_t               estado_dbg
);

  // Handshake: a byte moves on a rising edge where byte_valid && byte_ready;
  // byte_ready is registered and never depends on byte_valid.
  localparam int          RW         = $clog2(RELEASE_CYCLES + 1);
  localparam logic [16:0] CAPACIDADE = 17'(1) << ADDR_WIDTH;

  estado_t               r_estado, w_prox;
  logic                  r_byte_ready, r_imem_we, r_proc_reset, r_ocupado, r_erro;
  logic [ADDR_WIDTH-1:0] r_imem_addr;
  logic [31:0]           r_imem_wdata;
  logic [ADDR_WIDTH:0]   r_palavras;
  logic [7:0]            r_soma, r_n_alto;
  logic [15:0]           r_n;
  logic                  r_hdr_idx;
  logic [RW-1:0]         r_rel;

  logic        w_aceito, w_hdr_fim, w_pronta, w_ultima, w_inicia;
  logic [15:0] w_n;
  logic [7:0]  w_soma;
  logic [31:0] w_palavra;

  assign w_aceito  = byte_valid && r_byte_ready;
  assign w_hdr_fim = w_aceito && (r_estado == CONTAGEM) &&
                     (r_hdr_idx == 1'(BYTES_CABECALHO - 1));
  assign w_n       = {r_n_alto, byte_dado};
  assign w_soma    = r_soma + byte_dado;
  assign w_ultima  = w_pronta && ((17'(r_palavras) + 17'd1) == {1'b0, r_n});
  assign w_inicia  = (w_prox == CONTAGEM) && (r_estado != CONTAGEM);

  montador_palavra u_montador (
    .clk              (clk),
    .reset            (reset),
    .i_limpar         (w_inicia),
    .i_aceito         (w_aceito && (r_estado == DADOS)),
    .i_byte           (byte_dado),
    .o_palavra        (w_palavra),
    .o_palavra_pronta (w_pronta)
  );

  always_comb begin
    w_prox = r_estado;
    case (r_estado)
      OCIOSO, EXECUTA, ERRO: if (carregar) w_prox = CONTAGEM;
      CONTAGEM: begin
        if (w_hdr_fim) begin
          if (w_n == 16'd0)                    w_prox = CHECKSUM;
          else if ({1'b0, w_n} > CAPACIDADE)   w_prox = ERRO;
          else                                 w_prox = DADOS;
        end
      end
      DADOS:    if (w_ultima) w_prox = CHECKSUM;
      CHECKSUM: if (w_aceito) w_prox = (w_soma == 8'd0) ? LIBERA : ERRO;
      LIBERA:   if (r_rel == RW'(RELEASE_CYCLES - 1)) w_prox = EXECUTA;
      default:  w_prox = OCIOSO;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_estado     <= OCIOSO;
      r_byte_ready <= 1'b0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_proc_reset <= 1'b1;
      r_ocupado    <= 1'b0;
      r_erro       <= 1'b0;
      r_palavras   <= '0;
      r_soma       <= '0;
      r_n_alto     <= '0;
      r_n          <= '0;
      r_hdr_idx    <= 1'b0;
      r_rel        <= '0;
    end else begin
      r_estado     <= w_prox;
      r_byte_ready <= aceita_bytes(w_prox);
      r_ocupado    <= em_carga(w_prox);
      r_proc_reset <= (w_prox != EXECUTA);
      r_erro       <= (w_prox == ERRO);
      r_imem_we    <= w_pronta;
      r_rel        <= (r_estado == LIBERA) ? r_rel + RW'(1) : '0;
      if (w_inicia) begin
        r_soma     <= '0;
        r_palavras <= '0;
        r_n_alto   <= '0;
        r_n        <= '0;
        r_hdr_idx  <= 1'b0;
      end else begin
        if (w_aceito) r_soma <= w_soma;
        if (w_aceito && (r_estado == CONTAGEM)) begin
          r_hdr_idx <= r_hdr_idx + 1'b1;
          r_n_alto  <= byte_dado;
          if (w_hdr_fim) r_n <= w_n;
        end
        if (w_pronta) begin
          r_imem_addr  <= r_palavras[ADDR_WIDTH-1:0];
          r_imem_wdata <= w_palavra;
          r_palavras   <= r_palavras + 1'b1;
        end
      end
    end
  end

  assign byte_ready = r_byte_ready;
  assign imem_we    = r_imem_we;
  assign imem_addr  = r_imem_addr;
  assign imem_wdata = r_imem_wdata;
  assign proc_reset = r_proc_reset;
  assign ocupado    = r_ocupado;
  assign erro       = r_erro;
  assign palavras   = r_palavras;
  assign estado_dbg = r_estado;

endmodule

// File: tb/tb_carregador_programa.sv
// Self-checking bench for carregador_programa: table of load scenarios plus
// random loads, each checked against a stream-level model of the loader.
module tb_carregador_programa;
  import carregador_programa_pkg::*;

  localparam int AW  = 8;
  localparam int RC  = 2;
  localparam int CAP = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          carregar = 1'b0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_dado = 8'h00;
  logic          byte_ready, imem_we, proc_reset, ocupado, erro;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   palavras;
  estado_t       estado_dbg;

  carregador_programa #(.ADDR_WIDTH(AW), .RELEASE_CYCLES(RC)) dut (
    .clk        (clk),
    .reset      (reset),
    .carregar   (carregar),
    .byte_valid (byte_valid),
    .byte_dado  (byte_dado),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .proc_reset (proc_reset),
    .ocupado    (ocupado),
    .erro       (erro),
    .palavras   (palavras),
    .estado_dbg (estado_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [39:0] exp_q[$];
  logic [39:0] got_q[$];
  logic [7:0]  stream[$];
  logic [31:0] wfix[2];

  // Write monitor: each imem_we pulse is one cycle wide, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset && imem_we) got_q.push_back({imem_addr, imem_wdata});
  end

  task automatic chk(input string nome, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nome, got, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_proc_reset"}, 64'(proc_reset), 64'd1);
    chk({tag, "_byte_ready"}, 64'(byte_ready), 64'd0);
    chk({tag, "_imem_we"},    64'(imem_we),    64'd0);
    chk({tag, "_imem_addr"},  64'(imem_addr),  64'd0);
    chk({tag, "_imem_wdata"}, 64'(imem_wdata), 64'd0);
    chk({tag, "_ocupado"},    64'(ocupado),    64'd0);
    chk({tag, "_erro"},       64'(erro),       64'd0);
    chk({tag, "_palavras"},   64'(palavras),   64'd0);
    chk({tag, "_estado"},     64'(estado_dbg), 64'(OCIOSO));
  endtask

  // Reference model: builds the byte stream and the expected memory writes
  // directly from the framing and checksum rules.
  task automatic build(input int n, input bit bad, input bit fixo);
    logic [7:0]  s;
    logic [31:0] w;
    logic [15:0] n16;
    stream.delete();
    exp_q.delete();
    n16 = 16'(n);
    stream.push_back(n16[15:8]);
    stream.push_back(n16[7:0]);
    for (int i = 0; i < n; i++) begin
      w = fixo ? wfix[i % 2] : $urandom;
      stream.push_back(w[31:24]);
      stream.push_back(w[23:16]);
      stream.push_back(w[15:8]);
      stream.push_back(w[7:0]);
      if (n <= CAP) exp_q.push_back({8'(i), w});
    end
    s = 8'd0;
    foreach (stream[k]) s = s + stream[k];
    stream.push_back(8'(8'd0 - s + (bad ? 8'd1 : 8'd0)));
  endtask

  // driver tasks: called at a negedge, return at the negedge after the transfer
  task automatic send_byte(input logic [7:0] b);
    int w;
    byte_valid = 1'b1;
    byte_dado  = b;
    w = 0;
    while (!byte_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!byte_ready) chk("byte_ready_timeout", 64'(byte_ready), 64'd1);
    else @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic pulse_carregar(input string tag);
    @(negedge clk);
    carregar = 1'b1;
    @(negedge clk);
    carregar = 1'b0;
    chk({tag, "_start_proc_reset"}, 64'(proc_reset), 64'd1);
    chk({tag, "_start_ocupado"},    64'(ocupado),    64'd1);
    chk({tag, "_start_erro"},       64'(erro),       64'd0);
    chk({tag, "_start_palavras"},   64'(palavras),   64'd0);
    chk({tag, "_start_ready"},      64'(byte_ready), 64'd1);
  endtask

  task automatic run_load(input string tag, input int n, input bit bad, input bit stall,
                          input bit fixo, input bit exp_erro, input int exp_pal);
    int n_send;
    int d;
    build(n, bad, fixo);
    got_q.delete();
    pulse_carregar(tag);
    n_send = (n > CAP) ? 2 : stream.size();
    for (int i = 0; i < n_send; i++) begin
      if (stall) repeat ($urandom_range(0, 3)) @(negedge clk);
      if (stall && i == 5) carregar = 1'b1;
      send_byte(stream[i]);
      carregar = 1'b0;
      d = i - 2;
      if (i >= 2 && d < 4 * n && n <= CAP && (d % 4) == 3) begin
        chk({tag, "_we_latency"}, 64'(imem_we), 64'd1);
        chk({tag, "_we_word"}, 64'({imem_addr, imem_wdata}), 64'(exp_q[d / 4]));
      end
    end
    if (exp_erro) begin
      chk({tag, "_erro"},       64'(erro),       64'd1);
      chk({tag, "_err_reset"},  64'(proc_reset), 64'd1);
      chk({tag, "_err_ocup"},   64'(ocupado),    64'd0);
      chk({tag, "_err_ready"},  64'(byte_ready), 64'd0);
      chk({tag, "_err_estado"}, 64'(estado_dbg), 64'(ERRO));
    end else begin
      chk({tag, "_rel0_reset"}, 64'(proc_reset), 64'd1);
      chk({tag, "_rel0_ocup"},  64'(ocupado),    64'd1);
      @(negedge clk);
      chk({tag, "_rel1_reset"}, 64'(proc_reset), 64'd1);
      @(negedge clk);
      chk({tag, "_rel2_reset"}, 64'(proc_reset), 64'd0);
      chk({tag, "_rel2_ocup"},  64'(ocupado),    64'd0);
      chk({tag, "_rel2_erro"},  64'(erro),       64'd0);
      chk({tag, "_estado"},     64'(estado_dbg), 64'(EXECUTA));
    end
    repeat (2) @(negedge clk);
    chk({tag, "_palavras"}, 64'(palavras), 64'(exp_pal));
    chk({tag, "_n_writes"}, 64'(got_q.size()), 64'(exp_q.size()));
    foreach (exp_q[k]) begin
      if (k < got_q.size()) chk({tag, "_write"}, 64'(got_q[k]), 64'(exp_q[k]));
    end
  endtask

  typedef struct {
    string nome;
    int    n;
    bit    bad;
    bit    stall;
    bit    fixo;
    bit    exp_erro;
    int    exp_pal;
  } vec_t;

  vec_t tab[7];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wfix[0] = 32'h20080005;
    wfix[1] = 32'h01095020;
    tab[0] = '{"good2",    2,   1'b0, 1'b0, 1'b1, 1'b0, 2};
    tab[1] = '{"badsum",   2,   1'b1, 1'b0, 1'b1, 1'b1, 2};
    tab[2] = '{"empty",    0,   1'b0, 1'b0, 1'b0, 1'b0, 0};
    tab[3] = '{"oversize", 257, 1'b0, 1'b0, 1'b0, 1'b1, 0};
    tab[4] = '{"stall",    2,   1'b0, 1'b1, 1'b1, 1'b0, 2};
    tab[5] = '{"one_bad",  1,   1'b1, 1'b1, 1'b0, 1'b1, 1};
    tab[6] = '{"full",     256, 1'b0, 1'b0, 1'b0, 1'b0, 256};

    #3 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("por");
    reset = 1'b1;
    @(negedge clk);
    chk("idle_ready", 64'(byte_ready), 64'd0);

    foreach (tab[i])
      run_load(tab[i].nome, tab[i].n, tab[i].bad, tab[i].stall, tab[i].fixo,
               tab[i].exp_erro, tab[i].exp_pal);

    for (int r = 0; r < 6; r++) begin
      int  n;
      bit  bad;
      n   = $urandom_range(0, 12);
      bad = ($urandom_range(0, 3) == 0);
      run_load("rand", n, bad, 1'($urandom_range(0, 1)), 1'b0, bad, n);
    end

    // Reset arriving mid-load, after five data bytes.
    build(3, 1'b0, 1'b0);
    pulse_carregar("midrst");
    for (int i = 0; i < 7; i++) send_byte(stream[i]);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 chk_reset_vals("midrst_async");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("midrst_after");
    run_load("reload", 3, 1'b0, 1'b0, 1'b0, 1'b0, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
